// File: rtl/ahb_mem_latn.sv
// AHB-Lite single-port memory slave with fixed wait states and two-cycle ERROR responses.
// Optional sub-word writes: define AHB_MEM_BYTE_LANES_EN.
module ahb_mem_latn #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 7
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_ERR1, ST_ERR2} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [AW-1:0] idx_reg;
  logic          write_reg;
  logic [3:0]    strb_reg;
  logic [3:0]    byp_strb_reg;
  logic [31:0]   byp_data_reg;
  logic [31:0]   ram_q;
  logic [31:0]   rd_word;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept, err_in, align_err, commit, load_rd;
  logic [3:0]    strb_in;
  logic [AW-1:0] haddr_idx, rd_idx;
  logic          unused;

  assign unused    = HTRANS[0];
  assign haddr_idx = HADDR[AW+1:2];
  assign accept    = HSEL & HREADY & HTRANS[1] &
                     ((state_reg == ST_IDLE) | (state_reg == ST_DONE) | (state_reg == ST_ERR2));

`ifdef AHB_MEM_BYTE_LANES_EN
  always_comb begin
    align_err = ((HSIZE == 3'd1) && HADDR[0]) || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    case (HSIZE)
      3'd0:    strb_in = 4'b0001 << HADDR[1:0];
      3'd1:    strb_in = 4'b0011 << {HADDR[1], 1'b0};
      default: strb_in = 4'b1111;
    endcase
  end
`else
  assign align_err = (HADDR[1:0] != 2'b00);
  assign strb_in   = 4'b1111;
`endif

  assign err_in = ({1'b0, HADDR} >= BYTE_LIMIT) | align_err | (HSIZE > 3'd2);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        HRESP = (state_reg == ST_ERR2);
        if (accept) begin
          if (err_in) begin
            state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next = ST_WAIT;
            cnt_next   = WS_INIT;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_reg == 4'd0) state_next = ST_DONE;
        else cnt_next = cnt_reg - 4'd1;
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = ST_ERR2;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign commit  = (state_reg == ST_DONE) & write_reg;
  assign load_rd = (state_next == ST_DONE);
  assign rd_idx  = (state_reg == ST_WAIT) ? idx_reg : haddr_idx;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      idx_reg      <= '0;
      write_reg    <= 1'b0;
      strb_reg     <= 4'd0;
      byp_strb_reg <= 4'd0;
      byp_data_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        idx_reg   <= haddr_idx;
        write_reg <= HWRITE & ~err_in;
        strb_reg  <= strb_in;
      end
      // A read landing on the word being committed this same edge sees the new bytes.
      byp_strb_reg <= (load_rd && commit && (rd_idx == idx_reg)) ? strb_reg : 4'd0;
      byp_data_reg <= HWDATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_reg[b]) mem[idx_reg][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
    if (load_rd) ram_q <= mem[rd_idx];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_word[8*gi +: 8] = byp_strb_reg[gi] ? byp_data_reg[8*gi +: 8] : ram_q[8*gi +: 8];
  end

  assign HRDATA = ((state_reg == ST_DONE) && !write_reg) ? rd_word : 32'd0;

endmodule
